ram_sdp_clr: RTL
================

# ram_sdp_clr

Parametrised single-clock simple-dual-port RAM with a built-in memory-clear engine and a registered, valid-qualified read port. It is the generalised successor of the fixed 8×64 dual-port RAM wrapper, for use as a scratch/lookup buffer inside one clock domain. The RAM is cleared to a known value after every reset and on request, and can run read-first or write-first on same-address collisions.

## Interface
- `DATA_W`, 8, data word width in bits (1..64)
- `ADDR_W`, 6, address width; depth is `DEPTH = 2**ADDR_W` words (ADDR_W 1..12)
- `INIT_VAL`, 0, `DATA_W`-bit value written to every word by the clear engine

- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `clr_req`  in  1  one-cycle pulse that starts a full-memory clear
- `busy`  out  1  high while the clear engine is running
- `wr_en`  in  1  write enable
- `wr_addr`  in  ADDR_W  write address
- `wr_data`  in  DATA_W  write data
- `rd_en`  in  1  read enable
- `rd_addr`  in  ADDR_W  read address
- `rd_data`  out  DATA_W  read data, registered
- `rd_valid`  out  1  one-cycle strobe qualifying `rd_data`

## Operation
- Two-state FSM: CLEAR and RUN. Reset state is CLEAR with clear counter = 0.
- CLEAR: each cycle writes `INIT_VAL` to address = counter, then increments the counter. After writing address DEPTH-1, the FSM goes to RUN and the counter wraps to 0. `busy` = 1 throughout.
- In CLEAR, `wr_en`, `rd_en` and `clr_req` are ignored. There is no queuing and no restart.
- RUN: `wr_en` writes `wr_data` to `wr_addr`. `rd_en` reads `rd_addr`. Both may be active in the same cycle at any addresses.
- RUN and `clr_req` = 1: reads and writes presented in that same cycle are still performed. The FSM enters CLEAR on the next edge, starting at address 0.
- `rd_data` holds its last value whenever `rd_valid` = 0.
- Collision (`rd_en` & `wr_en` & `rd_addr == wr_addr` in RUN): behaviour is set by the Configuration section.
- Memory contents are not touched by `rst_n` itself. Only the clear engine initialises them.
- Asynchronous reset mid-clear or mid-operation aborts everything. The clear restarts from address 0 after release.

## Timing
- Reset values: `busy` = 1, `rd_valid` = 0, `rd_data` = 0, FSM = CLEAR, counter = 0.
- After `rst_n` deasserts, `busy` stays high for exactly DEPTH rising edges, then drops. The first RUN-cycle access is accepted on the edge after `busy` is seen low.
- `clr_req` sampled high in RUN at edge N: `busy` is high from after edge N until after edge N+DEPTH.
- Read latency is 1 cycle. `rd_en` sampled at edge N gives `rd_data`/`rd_valid` = 1 after edge N. `rd_valid` drops after edge N+1 unless `rd_en` is high again.
- Back-to-back reads give one word per cycle.
- A write at edge N is visible to a read sampled at edge N+1 or later.
- `busy`, `rd_valid` and `rd_data` are all driven straight from flops. There is no combinational input-to-output path.

## Configuration
- `RAM_SDP_CLR_BYPASS_EN` defined: write-first. On a collision, `rd_data` returns the `wr_data` of that same cycle, through a registered bypass mux.
- Not defined: read-first. On a collision, `rd_data` returns the old stored word. The storage maps to a plain block RAM with no bypass logic.

## Test plan
- Reset, then DEPTH = 64: `busy` is high for exactly 64 cycles after release. Reading addresses 0, 31 and 63 then returns `INIT_VAL` (0), each with a single-cycle `rd_valid`.
- Write 0xA5 to address 5 and 0x3C to address 63, then read 63 and 5 back-to-back: `rd_data` = 0x3C, then 0xA5, on consecutive cycles with `rd_valid` high both cycles.
- Collision: with address 9 holding 0x11, write 0x77 to address 9 and read address 9 in the same cycle.
  - Macro defined: `rd_data` = 0x77.
  - Macro undefined: `rd_data` = 0x11.
  - A read of address 9 on the next cycle returns 0x77 in both builds.
- Fill addresses with non-zero data, pulse `clr_req` together with a write of 0xEE to address 2. Required response:
  - The write lands.
  - `busy` is high for 64 cycles.
  - Reads and writes issued during `busy` produce no `rd_valid` and do not modify memory.
  - Every address reads 0 afterwards.
- Assert `rst_n` low for one cycle while the clear is at address 30 and while `rd_en` is pending: `rd_valid` and `rd_data` go to 0 immediately, and `busy` stays high for a full 64 cycles after release.
- Parameter sweep with DATA_W = 16, ADDR_W = 4, INIT_VAL = 0xFFFF: `busy` lasts 16 cycles, every address reads 0xFFFF, and a write/readback of 0x1234 at address 15 returns 0x1234.

Source files
------------

// File: rtl/ram_sdp_clr.sv
// ram_sdp_clr: single-clock simple-dual-port RAM with clear engine and registered, valid-qualified read.
// Define RAM_SDP_CLR_BYPASS_EN for write-first collisions; the default build is read-first.
module ram_sdp_clr #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);
    typedef enum logic {CLEAR, RUN} state_t;
    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              busy_q;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic              run;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    // The clear engine owns the single write port while not in RUN.
    assign run      = state_q == RUN;
    assign mem_we   = rst_n && (!run || wr_en);
    assign mem_addr = run ? wr_addr : cnt_q;
    assign mem_data = run ? wr_data : INIT_VAL;
`ifdef RAM_SDP_CLR_BYPASS_EN
    assign rd_data_d = (wr_en && wr_addr == rd_addr) ? wr_data : mem[rd_addr];
`else
    assign rd_data_d = mem[rd_addr];
`endif

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CLEAR;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= run && rd_en;
            if (run && rd_en) rd_data_q <= rd_data_d;
            if (!run) begin
                cnt_q <= cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_q <= RUN;
                    busy_q  <= 1'b0;
                end
            end else if (clr_req) begin
                state_q <= CLEAR;
                cnt_q   <= '0;
                busy_q  <= 1'b1;
            end
        end
    end

    assign busy     = busy_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
endmodule
